// File: rtl/rt_ibex_pcs_pkg.sv
// Shared definitions for the parallel context-save LIFO and its restore sequencer.
// The register order here must match the order the LIFO uses when it saves.
package rt_ibex_pcs_pkg;

  localparam int unsigned PCS_NR_SAVED_REGS = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } pcs_restore_state_t;

  // Element i is the architectural register that context slot i restores: x1,x5,x6,x7,x10..x14.
  localparam logic [PCS_NR_SAVED_REGS-1:0][4:0] PCS_REG_ADDR = {
    5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd1
  };

endpackage

// File: rtl/rt_ibex_pcs_restore_seq.sv
// Writes a popped context back into the register file, one register per cycle,
// yielding the shared write port to in-flight core writebacks.
//
// state | meaning
// IDLE  | waiting for a restore pulse
// WRITE | writing buf[idx] to PCS_REG_ADDR[idx]; stalls while the core owns the port
// DONE  | one-cycle completion pulse, still busy
module rt_ibex_pcs_restore_seq
  import rt_ibex_pcs_pkg::*;
#(
  parameter int unsigned NrSavedRegs  = PCS_NR_SAVED_REGS,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegAddrWidth = 5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   restore_en_i,
  input  logic [NrSavedRegs-1:0][DataWidth-1:0]  restore_data_i,
  input  logic                                   core_we_i,
  output logic                                   rf_we_o,
  output logic [RegAddrWidth-1:0]                rf_waddr_o,
  output logic [DataWidth-1:0]                   rf_wdata_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   err_o
);

  localparam int unsigned IdxW = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;

  pcs_restore_state_t                    r_state;
  pcs_restore_state_t                    w_state_next;
  logic [IdxW-1:0]                       r_idx;
  logic                                  r_err;
  logic [NrSavedRegs-1:0][DataWidth-1:0] r_buf;

  logic w_accept;
  logic w_write;
  logic w_last;

  assign w_accept = (r_state == IDLE) && restore_en_i;
  assign w_write  = (r_state == WRITE) && !core_we_i;
  assign w_last   = (r_idx == IdxW'(NrSavedRegs - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_idx <= '0;
      end else if (w_write && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
      // A pop arriving while a restore is still in flight is lost; flag it until reset.
      if (restore_en_i && (r_state != IDLE)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_accept) begin
      r_buf <= restore_data_i;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (restore_en_i) w_state_next = WRITE;
      WRITE:   if (w_write && w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (r_state)
      WRITE: begin
        busy_o = 1'b1;
        if (!core_we_i) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = RegAddrWidth'(PCS_REG_ADDR[r_idx]);
          rf_wdata_o = r_buf[r_idx];
        end
      end
      DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign err_o = r_err;

endmodule

// File: tb/tb_rt_ibex_pcs_restore_seq.sv
// Directed bench for the context restore sequencer: latency, stalls, overlap errors,
// mid-restore reset and back-to-back restores.
module tb_rt_ibex_pcs_restore_seq;

  logic              clk;
  logic              rst;
  logic              restore_en;
  logic [8:0][31:0]  restore_data;
  logic              core_we;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] exp_addr [9] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};

  rt_ibex_pcs_restore_seq dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .restore_en_i   (restore_en),
    .restore_data_i (restore_data),
    .core_we_i      (core_we),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_step(input logic [31:0] exp_err);
    @(posedge clk); #1;
    restore_en = 1'b0;
    core_we    = 1'b0;
    #3;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_we",   32'(rf_we), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_err",  32'(err), exp_err);
  endtask

  // Pulse a restore, then walk the following cycles; stall_mask bit k drives core_we at T+k,
  // dbl_at > 0 raises a second restore request at T+dbl_at.
  task automatic do_restore(input logic [31:0] base, input logic [31:0] stall_mask,
                            input int dbl_at, input int exp_done_cyc);
    int widx;
    int done_cyc;
    @(posedge clk); #1;
    restore_en = 1'b1;
    core_we    = 1'b0;
    for (int i = 0; i < 9; i++) restore_data[i] = base + 32'(i);
    #3;
    chk("start_busy", 32'(busy), 0);
    chk("start_we",   32'(rf_we), 0);
    widx = 0;
    done_cyc = 0;
    for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
      @(posedge clk); #1;
      restore_en = (k == dbl_at);
      if (k == dbl_at)
        for (int i = 0; i < 9; i++) restore_data[i] = 32'hDEAD_0000 + 32'(i);
      core_we = stall_mask[k];
      #3;
      chk("busy", 32'(busy), 1);
      if (widx == 9) begin
        chk("done_pulse", 32'(done), 1);
        chk("done_we", 32'(rf_we), 0);
        done_cyc = k;
      end else if (stall_mask[k]) begin
        chk("stall_we",    32'(rf_we), 0);
        chk("stall_addr",  32'(rf_waddr), 0);
        chk("stall_data",  rf_wdata, 0);
        chk("stall_done",  32'(done), 0);
      end else begin
        chk("wr_we",   32'(rf_we), 1);
        chk("wr_addr", 32'(rf_waddr), 32'(exp_addr[widx]));
        chk("wr_data", rf_wdata, base + 32'(widx));
        chk("wr_done", 32'(done), 0);
        widx++;
      end
    end
    chk("done_cycle", 32'(done_cyc), 32'(exp_done_cyc));
  endtask

  initial begin
    rst          = 1'b1;
    restore_en   = 1'b0;
    core_we      = 1'b0;
    restore_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("rst_we",    32'(rf_we), 0);
    chk("rst_addr",  32'(rf_waddr), 0);
    chk("rst_data",  rf_wdata, 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);

    // core_we in IDLE must do nothing
    @(posedge clk); #1; core_we = 1'b1; #3;
    chk("idle_core_we", 32'(rf_we), 0);
    chk("idle_core_busy", 32'(busy), 0);

    // basic restore: done at T+10, idle at T+11
    do_restore(32'hA000_0000, 32'h0, 0, 10);
    idle_step(0);

    // stalls at T+1 and T+4 push done to T+12
    do_restore(32'hA000_0000, 32'h0000_0012, 0, 12);
    idle_step(0);

    // overlapping request at T+3 is ignored, buffer kept, err sticky
    do_restore(32'hA000_0000, 32'h0, 3, 10);
    idle_step(1);
    idle_step(1);

    // reset at T+4 abandons the restore
    @(posedge clk); #1;
    rst = 1'b0; restore_en = 1'b1; core_we = 1'b0;
    for (int i = 0; i < 9; i++) restore_data[i] = 32'hB000_0000 + 32'(i);
    repeat (3) begin @(posedge clk); #1; restore_en = 1'b0; end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; #3;
    chk("mid_rst_we",   32'(rf_we), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err",  32'(err), 0);
    idle_step(0);
    do_restore(32'hC000_0000, 32'h0, 0, 10);
    idle_step(0);

    // back-to-back: second pulse in the first IDLE cycle after done
    do_restore(32'h1111_0000, 32'h0, 0, 10);
    do_restore(32'h2222_0000, 32'h0, 0, 10);
    idle_step(0);

    // request during DONE is ignored but flagged
    do_restore(32'h3333_0000, 32'h0, 10, 10);
    idle_step(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
